// File: rtl/downsampler_frame_controller_if.sv
// Bus between the frame controller and its surroundings: camera pixels, downsampler link,
// bin output and status. Clock and reset stay outside as plain ports.
interface downsampler_frame_controller_if #(
  parameter int data_width = 8,
  parameter int addr_width = 11
);
  logic                  i_start;
  logic                  i_abort;
  logic                  i_pix_valid;
  logic [data_width-1:0] i_pix_data;
  logic                  o_ds_clear;
  logic                  o_ds_in_valid;
  logic [data_width-1:0] o_ds_in;
  logic                  i_ds_out_valid;
  logic [data_width-1:0] i_ds_out;
  logic                  o_bin_valid;
  logic [data_width-1:0] o_bin_data;
  logic [addr_width-1:0] o_bin_addr;
  logic                  o_busy;
  logic                  o_frame_done;
  logic                  o_error;

  // slave: the controller itself
  modport slave (
    input  i_start, i_abort, i_pix_valid, i_pix_data, i_ds_out_valid, i_ds_out,
    output o_ds_clear, o_ds_in_valid, o_ds_in, o_bin_valid, o_bin_data, o_bin_addr,
           o_busy, o_frame_done, o_error
  );

  // master: camera, downsampler and consumer side
  modport master (
    output i_start, i_abort, i_pix_valid, i_pix_data, i_ds_out_valid, i_ds_out,
    input  o_ds_clear, o_ds_in_valid, o_ds_in, o_bin_valid, o_bin_data, o_bin_addr,
           o_busy, o_frame_done, o_error
  );
endinterface

// File: rtl/downsampler_frame_controller.sv
// Frame sequencer in front of grayscale_downsampler: clears it, crops partial bins,
// tags returned bins with a linear address and reports done / overrun / drain timeout.
module downsampler_frame_controller #(
  parameter int data_width    = 8,
  parameter int image_width   = 320,
  parameter int image_height  = 240,
  parameter int bin_width     = 6,
  parameter int bin_height    = 12,
  parameter int drain_timeout = 4096
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  downsampler_frame_controller_if.slave   bus
);
  localparam int BINS_X   = image_width / bin_width;
  localparam int BINS_Y   = image_height / bin_height;
  localparam int NUM_BINS = BINS_X * BINS_Y;
  localparam int CROP_W   = BINS_X * bin_width;
  localparam int CROP_H   = BINS_Y * bin_height;
  localparam int X_W      = $clog2(image_width);
  localparam int Y_W      = $clog2(image_height);
  localparam int CNT_W    = $clog2(NUM_BINS + 1);
  localparam int ADDR_W   = $clog2(NUM_BINS);
  localparam int D_W      = $clog2(drain_timeout + 1);

  localparam logic [X_W-1:0]   X_LAST    = X_W'(image_width - 1);
  localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(image_height - 1);
  localparam logic [X_W:0]     CROP_W_E  = (X_W+1)'(CROP_W);
  localparam logic [Y_W:0]     CROP_H_E  = (Y_W+1)'(CROP_H);
  localparam logic [CNT_W-1:0] BIN_FULL  = CNT_W'(NUM_BINS);
  localparam logic [CNT_W-1:0] BIN_LAST  = CNT_W'(NUM_BINS - 1);
  localparam logic [D_W-1:0]   DRAIN_END = D_W'(drain_timeout - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]            r_state;
  logic                  r_clr_cnt;
  logic [X_W-1:0]        r_x;
  logic [Y_W-1:0]        r_y;
  logic [CNT_W-1:0]      r_bin_cnt;
  logic [D_W-1:0]        r_drain_cnt;
  logic                  r_ds_clear;
  logic                  r_ds_in_valid;
  logic [data_width-1:0] r_ds_in;
  logic                  r_bin_valid;
  logic [data_width-1:0] r_bin_data;
  logic [ADDR_W-1:0]     r_bin_addr;
  logic                  r_error;

  logic w_in_crop, w_last_pix, w_bin_ok, w_overrun;

  assign w_in_crop  = ({1'b0, r_x} < CROP_W_E) && ({1'b0, r_y} < CROP_H_E);
  assign w_last_pix = (r_x == X_LAST) && (r_y == Y_LAST);
  // Bins are only accepted while a frame is collecting and the bin space is not exhausted.
  assign w_bin_ok   = ((r_state == S_STREAM) || (r_state == S_DRAIN)) && (r_bin_cnt != BIN_FULL);
  assign w_overrun  = bus.i_pix_valid && ((r_state == S_DRAIN) || (r_state == S_DONE));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_clr_cnt     <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_bin_cnt     <= '0;
      r_drain_cnt   <= '0;
      r_ds_clear    <= 1'b1;
      r_ds_in_valid <= 1'b0;
      r_ds_in       <= '0;
      r_bin_valid   <= 1'b0;
      r_bin_data    <= '0;
      r_bin_addr    <= '0;
      r_error       <= 1'b0;
    end else begin
      r_ds_clear    <= 1'b0;
      r_ds_in_valid <= 1'b0;
      r_bin_valid   <= 1'b0;
      if (bus.i_abort) begin
        // Abort drops any bin arriving this cycle and leaves the error flag alone.
        r_state    <= S_IDLE;
        r_ds_clear <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.i_start) begin
              r_state     <= S_CLEAR;
              r_ds_clear  <= 1'b1;
              r_error     <= 1'b0;
              r_clr_cnt   <= 1'b0;
              r_x         <= '0;
              r_y         <= '0;
              r_bin_cnt   <= '0;
              r_drain_cnt <= '0;
            end
          end
          S_CLEAR: begin
            if (!r_clr_cnt) begin
              r_ds_clear <= 1'b1;
              r_clr_cnt  <= 1'b1;
            end else begin
              r_state <= S_STREAM;
            end
          end
          S_STREAM: begin
            if (bus.i_pix_valid) begin
              r_ds_in_valid <= w_in_crop;
              r_ds_in       <= bus.i_pix_data;
              if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
              end else begin
                r_x <= r_x + 1'b1;
              end
              if (w_last_pix) r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (bus.i_ds_out_valid) begin
              r_drain_cnt <= '0;
            end else if (r_drain_cnt == DRAIN_END) begin
              r_error    <= 1'b1;
              r_state    <= S_IDLE;
              r_ds_clear <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt + 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase

        if (w_overrun) r_error <= 1'b1;

        // Last bin takes priority over the STREAM->DRAIN move in the same cycle.
        if (bus.i_ds_out_valid) begin
          if (w_bin_ok) begin
            r_bin_valid <= 1'b1;
            r_bin_data  <= bus.i_ds_out;
            r_bin_addr  <= r_bin_cnt[ADDR_W-1:0];
            r_bin_cnt   <= r_bin_cnt + 1'b1;
            if (r_bin_cnt == BIN_LAST) r_state <= S_DONE;
          end else begin
            r_error <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_ds_clear    = r_ds_clear;
  assign bus.o_ds_in_valid = r_ds_in_valid;
  assign bus.o_ds_in       = r_ds_in;
  assign bus.o_bin_valid   = r_bin_valid;
  assign bus.o_bin_data    = r_bin_data;
  assign bus.o_bin_addr    = r_bin_addr;
  assign bus.o_busy        = (r_state != S_IDLE);
  assign bus.o_frame_done  = (r_state == S_DONE);
  assign bus.o_error       = r_error;
endmodule

// File: tb/tb_downsampler_frame_controller.sv
// Directed bench on a 5x5 image with 2x2 bins (4 bins, column 4 and line 4 cropped),
// drain timeout 8; the bench plays camera and downsampler by hand.
module tb_downsampler_frame_controller;
  localparam int DW = 8;
  localparam int IW = 5;
  localparam int IH = 5;
  localparam int BW = 2;
  localparam int BH = 2;
  localparam int DT = 8;
  localparam int CW = 4;
  localparam int CH = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  downsampler_frame_controller_if #(.data_width(DW), .addr_width(AW)) bus ();

  downsampler_frame_controller #(
    .data_width(DW), .image_width(IW), .image_height(IH),
    .bin_width(BW), .bin_height(BH), .drain_timeout(DT)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    logic [DW-1:0] d;
    logic          in_crop;
    d       = DW'(16 * y + x + 1);
    in_crop = (x < CW) && (y < CH);
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data  = d;
    tick();
    bus.i_pix_valid = 1'b0;
    chk1("ds_in_valid", bus.o_ds_in_valid, in_crop);
    if (in_crop) chkv("ds_in", 32'(bus.o_ds_in), 32'(d));
  endtask

  task automatic pixels(input int first, input int last);
    for (int i = first; i <= last; i++) pix(i % IW, i / IW);
  endtask

  task automatic bin(input logic [DW-1:0] d, input int a);
    bus.i_ds_out_valid = 1'b1;
    bus.i_ds_out       = d;
    tick();
    bus.i_ds_out_valid = 1'b0;
    chk1("bin_valid", bus.o_bin_valid, 1'b1);
    chkv("bin_data", 32'(bus.o_bin_data), 32'(d));
    chkv("bin_addr", 32'(bus.o_bin_addr), 32'(a));
  endtask

  task automatic start_frame();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk1("start_busy", bus.o_busy, 1'b1);
    chk1("start_err_clr", bus.o_error, 1'b0);
    chk1("clear_c1", bus.o_ds_clear, 1'b1);
    tick();
    chk1("clear_c2", bus.o_ds_clear, 1'b1);
    tick();
    chk1("clear_end", bus.o_ds_clear, 1'b0);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_pix_valid = 1'b0;
    bus.i_pix_data = '0;
    bus.i_ds_out_valid = 1'b0;
    bus.i_ds_out = '0;

    // reset state
    repeat (3) tick();
    chk1("rst_ds_clear", bus.o_ds_clear, 1'b1);
    chk1("rst_busy", bus.o_busy, 1'b0);
    chk1("rst_error", bus.o_error, 1'b0);
    chk1("rst_bin_valid", bus.o_bin_valid, 1'b0);
    chk1("rst_frame_done", bus.o_frame_done, 1'b0);
    chkv("rst_bin_addr", 32'(bus.o_bin_addr), 32'd0);
    rst_n = 1'b1;
    tick();
    chk1("idle_ds_clear", bus.o_ds_clear, 1'b0);
    chk1("idle_busy", bus.o_busy, 1'b0);

    // stray bin in IDLE
    bus.i_ds_out_valid = 1'b1;
    bus.i_ds_out = 8'h55;
    tick();
    bus.i_ds_out_valid = 1'b0;
    chk1("stray_no_bin", bus.o_bin_valid, 1'b0);
    chk1("stray_error", bus.o_error, 1'b1);

    // full frame with crop: two bins during STREAM, two in DRAIN
    start_frame();
    pixels(0, 9);
    bin(8'h11, 0);
    bin(8'h22, 1);
    pixels(10, 24);
    chk1("drain_busy", bus.o_busy, 1'b1);
    chk1("drain_no_done", bus.o_frame_done, 1'b0);
    bin(8'h33, 2);
    chk1("bin2_no_done", bus.o_frame_done, 1'b0);
    bin(8'h44, 3);
    chk1("frame_done", bus.o_frame_done, 1'b1);
    // extra bin beyond the frame, arriving in DONE
    bus.i_ds_out_valid = 1'b1;
    bus.i_ds_out = 8'h99;
    tick();
    bus.i_ds_out_valid = 1'b0;
    chk1("extra_no_bin", bus.o_bin_valid, 1'b0);
    chk1("extra_error", bus.o_error, 1'b1);
    chk1("done_pulse_end", bus.o_frame_done, 1'b0);
    chk1("done_idle", bus.o_busy, 1'b0);

    // abort mid-frame with an in-flight bin
    start_frame();
    pixels(0, 6);
    bin(8'h77, 0);
    bus.i_abort = 1'b1;
    bus.i_ds_out_valid = 1'b1;
    bus.i_ds_out = 8'h78;
    tick();
    bus.i_abort = 1'b0;
    bus.i_ds_out_valid = 1'b0;
    chk1("abort_busy", bus.o_busy, 1'b0);
    chk1("abort_clear", bus.o_ds_clear, 1'b1);
    chk1("abort_no_bin", bus.o_bin_valid, 1'b0);
    chk1("abort_no_done", bus.o_frame_done, 1'b0);
    chk1("abort_error", bus.o_error, 1'b0);
    tick();
    chk1("abort_clear_end", bus.o_ds_clear, 1'b0);

    // clean frame after abort, plus a pixel overrun in DRAIN
    start_frame();
    pixels(0, 24);
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data = 8'hEE;
    tick();
    bus.i_pix_valid = 1'b0;
    chk1("overrun_no_fwd", bus.o_ds_in_valid, 1'b0);
    chk1("overrun_error", bus.o_error, 1'b1);
    for (int a = 0; a < 4; a++) bin(DW'(8'h81 + a), a);
    chk1("frame2_done", bus.o_frame_done, 1'b1);
    tick();
    chk1("frame2_idle", bus.o_busy, 1'b0);
    chk1("frame2_err_sticky", bus.o_error, 1'b1);

    // drain timeout: downsampler stops one bin short
    start_frame();
    pixels(0, 24);
    for (int a = 0; a < 3; a++) bin(DW'(8'hC0 + a), a);
    repeat (DT - 1) tick();
    chk1("to_pre_busy", bus.o_busy, 1'b1);
    chk1("to_pre_error", bus.o_error, 1'b0);
    tick();
    chk1("to_busy", bus.o_busy, 1'b0);
    chk1("to_error", bus.o_error, 1'b1);
    chk1("to_clear", bus.o_ds_clear, 1'b1);
    chk1("to_no_done", bus.o_frame_done, 1'b0);
    tick();
    chk1("to_clear_end", bus.o_ds_clear, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
